// File: rtl/leaf_tx_packetizer.sv
// ---------------------------------------------------------------------------
// leaf_tx_packetizer
//
// Transmit side of a BFT leaf. Collects 32-bit words from the user kernel's
// output channels over a vld/ack handshake, picks one channel per cycle in
// round-robin order, and checks that the destination BRAM still has room
// (credits). Each accepted word leaves one cycle later as a 49-bit BFT packet.
// Before any traffic flows, a small route table is loaded in the config state.
//
// Ports
//   clk                      single clock, rising edge
//   reset                    synchronous, active-low
//   din_leaf_user2interface  user words, channel i at [32i+31:32i]
//   vld_user2interface       per-channel word valid
//   ack_interface2user       per-channel accept strobe (one-hot or zero, combinational)
//   cfg_we/cfg_port/cfg_leaf/cfg_dport  route table write (config state only)
//   cfg_done                 leave config state, start forwarding
//   credit_vld/credit_port   free-space return from the destination
//   dout_leaf_interface2bft  {leaf, port, valid, addr, payload}, registered
//   stat_pkt_cnt             emitted packet count
//
// Build option
//   LEAF_TX_STATS_EN  when defined, stat_pkt_cnt counts emitted packets
//                     (wraps at 2**32); otherwise it is tied to zero.
// ---------------------------------------------------------------------------
module leaf_tx_packetizer #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int NUM_OUT_PORTS         = 6,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]  din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]               vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]               ack_interface2user,
  input  logic                                   cfg_we,
  input  logic [2:0]                             cfg_port,
  input  logic [NUM_LEAF_BITS-1:0]               cfg_leaf,
  input  logic [NUM_PORT_BITS-1:0]               cfg_dport,
  input  logic                                   cfg_done,
  input  logic                                   credit_vld,
  input  logic [2:0]                             credit_port,
  output logic [PACKET_BITS-1:0]                 dout_leaf_interface2bft,
  output logic [31:0]                            stat_pkt_cnt
);

  localparam int IDX_BITS    = $clog2(NUM_OUT_PORTS);
  localparam int SCAN_BITS   = IDX_BITS + 1;
  localparam int CREDIT_MAX  = 2 ** NUM_ADDR_BITS;
  localparam int CREDIT_BITS = NUM_ADDR_BITS + 1;
  localparam int SUM_BITS    = NUM_ADDR_BITS + 2;

  localparam logic [0:0] S_CFG = 1'b0;
  localparam logic [0:0] S_RUN = 1'b1;

  logic [0:0]               state;
  logic [IDX_BITS-1:0]      rr_ptr;
  logic [NUM_LEAF_BITS-1:0] route_leaf  [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] route_dport [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]   credit      [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr        [NUM_OUT_PORTS];
  logic [SUM_BITS-1:0]      credit_sum  [NUM_OUT_PORTS];

  logic [NUM_OUT_PORTS-1:0] eligible;
  logic [SCAN_BITS-1:0]     scan_idx;
  logic                     grant_vld;
  logic [IDX_BITS-1:0]      grant_idx;
  logic [PAYLOAD_BITS-1:0]  grant_word;
  logic [NUM_LEAF_BITS-1:0] grant_leaf;
  logic [NUM_PORT_BITS-1:0] grant_dport;
  logic [NUM_ADDR_BITS-1:0] grant_addr;

  // A channel competes only while forwarding is enabled and its destination
  // still has at least one free BRAM slot.
  always_comb begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      eligible[i] = (state == S_RUN) && vld_user2interface[i] && (credit[i] != '0);
    end
  end

  // Round-robin scan starting at rr_ptr; the first eligible channel wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_OUT_PORTS; k++) begin
      scan_idx = {1'b0, rr_ptr} + SCAN_BITS'(k);
      if (scan_idx >= SCAN_BITS'(NUM_OUT_PORTS)) begin
        scan_idx = scan_idx - SCAN_BITS'(NUM_OUT_PORTS);
      end
      if (!grant_vld && eligible[scan_idx[IDX_BITS-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx[IDX_BITS-1:0];
      end
    end
  end

  // Mux out the winning channel's word, route entry and write address, and
  // drive its ack in the same cycle.
  always_comb begin
    ack_interface2user = '0;
    grant_word         = '0;
    grant_leaf         = '0;
    grant_dport        = '0;
    grant_addr         = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (grant_vld && (grant_idx == IDX_BITS'(i))) begin
        ack_interface2user[i] = 1'b1;
        grant_word            = din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
        grant_leaf            = route_leaf[i];
        grant_dport           = route_dport[i];
        grant_addr            = addr[i];
      end
    end
  end

  // Credit arithmetic is one bit wider than the counter so that a returned
  // block landing on an almost-full counter can be clamped back to the BRAM
  // depth instead of wrapping.
  always_comb begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      credit_sum[i] = SUM_BITS'(credit[i]);
      if (credit_vld && (credit_port == 3'(i))) begin
        credit_sum[i] = credit_sum[i] + SUM_BITS'(FREESPACE_UPDATE_SIZE);
      end
      if (grant_vld && (grant_idx == IDX_BITS'(i))) begin
        credit_sum[i] = credit_sum[i] - SUM_BITS'(1);
      end
    end
  end

  // Main sequential block. Output is registered and defaults to zero, so an
  // idle cycle (or a reset) produces an all-zero packet on the next edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state                   <= S_CFG;
      rr_ptr                  <= '0;
      dout_leaf_interface2bft <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        route_leaf[i]  <= '0;
        route_dport[i] <= '0;
        credit[i]      <= CREDIT_BITS'(CREDIT_MAX);
        addr[i]        <= '0;
      end
    end else begin
      dout_leaf_interface2bft <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        if (credit_sum[i] > SUM_BITS'(CREDIT_MAX)) begin
          credit[i] <= CREDIT_BITS'(CREDIT_MAX);
        end else begin
          credit[i] <= credit_sum[i][CREDIT_BITS-1:0];
        end
        if (grant_vld && (grant_idx == IDX_BITS'(i))) begin
          addr[i] <= addr[i] + 1'b1;
        end
      end
      case (state)
        S_CFG: begin
          for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            if (cfg_we && (cfg_port == 3'(i))) begin
              route_leaf[i]  <= cfg_leaf;
              route_dport[i] <= cfg_dport;
            end
          end
          if (cfg_done) begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (grant_vld) begin
            dout_leaf_interface2bft <= {grant_leaf, grant_dport, 1'b1, grant_addr, grant_word};
            rr_ptr <= (grant_idx == IDX_BITS'(NUM_OUT_PORTS - 1)) ? '0 : grant_idx + 1'b1;
          end
        end
        default: state <= S_CFG;
      endcase
    end
  end

`ifdef LEAF_TX_STATS_EN
  logic [31:0] pkt_cnt;

  // Counts packets as they are loaded into the output register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pkt_cnt <= '0;
    end else if (grant_vld) begin
      pkt_cnt <= pkt_cnt + 32'd1;
    end
  end

  assign stat_pkt_cnt = pkt_cnt;
`else
  assign stat_pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_leaf_tx_packetizer.sv
// ---------------------------------------------------------------------------
// tb_leaf_tx_packetizer
//
// Self-checking bench for leaf_tx_packetizer. A behavioural model of the
// arbiter, credits, addresses and route table predicts the ack and the packet
// for every driven cycle; predictions go into scoreboard queues and are
// popped when the DUT produces the corresponding output.
// ---------------------------------------------------------------------------
module tb_leaf_tx_packetizer;

  localparam int NP = 6;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [191:0] din = '0;
  logic [5:0]   vld = '0;
  logic [5:0]   ack;
  logic         cfg_we = 1'b0;
  logic [2:0]   cfg_port = '0;
  logic [4:0]   cfg_leaf = '0;
  logic [3:0]   cfg_dport = '0;
  logic         cfg_done = 1'b0;
  logic         credit_vld = 1'b0;
  logic [2:0]   credit_port = '0;
  logic [48:0]  dout;
  logic [31:0]  stat;

  int total_checks = 0;
  int pass_checks  = 0;

  logic [5:0]  exp_ack_q  [$];
  logic [48:0] exp_dout_q [$];
  logic [5:0]  ea;
  logic [48:0] ed;

  logic [4:0] m_leaf   [NP];
  logic [3:0] m_port   [NP];
  int         m_credit [NP];
  int         m_addr   [NP];
  int         m_rr;
  int         m_cnt;
  bit         m_run;

  leaf_tx_packetizer dut (
    .clk                     (clk),
    .reset                   (reset),
    .din_leaf_user2interface (din),
    .vld_user2interface      (vld),
    .ack_interface2user      (ack),
    .cfg_we                  (cfg_we),
    .cfg_port                (cfg_port),
    .cfg_leaf                (cfg_leaf),
    .cfg_dport               (cfg_dport),
    .cfg_done                (cfg_done),
    .credit_vld              (credit_vld),
    .credit_port             (credit_port),
    .dout_leaf_interface2bft (dout),
    .stat_pkt_cnt            (stat)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [191:0] makeData(input int tag, input int cyc);
    logic [191:0] r;
    r = '0;
    for (int i = 0; i < NP; i++) begin
      r[i*32 +: 32] = 32'hA000_0000 + 32'(tag << 20) + 32'(i << 16) + 32'(cyc);
    end
    return r;
  endfunction

  task automatic modelReset();
    m_run = 1'b0;
    m_rr  = 0;
    m_cnt = 0;
    for (int i = 0; i < NP; i++) begin
      m_leaf[i]   = '0;
      m_port[i]   = '0;
      m_credit[i] = 128;
      m_addr[i]   = 0;
    end
    exp_ack_q.delete();
    exp_dout_q.delete();
  endtask

  // Drives one cycle of user/credit inputs and predicts ack and packet.
  task automatic applyStimulus(input logic [5:0] v, input logic [191:0] d,
                               input logic cv, input logic [2:0] cp);
    int g;
    int idx;
    int cr;
    logic [5:0]  pa;
    logic [48:0] pd;
    @(negedge clk);
    reset       = 1'b1;
    vld         = v;
    din         = d;
    credit_vld  = cv;
    credit_port = cp;
    cfg_we      = 1'b0;
    cfg_done    = 1'b0;
    g = -1;
    if (m_run) begin
      for (int k = 0; k < NP; k++) begin
        idx = (m_rr + k) % NP;
        if (g < 0 && v[idx] && m_credit[idx] > 0) g = idx;
      end
    end
    pa = '0;
    pd = '0;
    if (g >= 0) begin
      pa[g] = 1'b1;
      pd = {m_leaf[g], m_port[g], 1'b1, 7'(m_addr[g]), d[g*32 +: 32]};
      m_addr[g] = (m_addr[g] + 1) % 128;
      m_rr = (g + 1) % NP;
      m_cnt++;
    end
    for (int i = 0; i < NP; i++) begin
      cr = m_credit[i];
      if (g == i) cr = cr - 1;
      if (cv && int'(cp) == i) cr = cr + 64;
      if (cr > 128) cr = 128;
      m_credit[i] = cr;
    end
    exp_ack_q.push_back(pa);
    exp_dout_q.push_back(pd);
  endtask

  // One cycle of route-table write; user valids are held low meanwhile.
  task automatic cfgWrite(input logic [2:0] p, input logic [4:0] lf,
                          input logic [3:0] dp, input logic done);
    @(negedge clk);
    reset      = 1'b1;
    vld        = '0;
    credit_vld = 1'b0;
    cfg_we     = 1'b1;
    cfg_port   = p;
    cfg_leaf   = lf;
    cfg_dport  = dp;
    cfg_done   = done;
    if (!m_run) begin
      if (int'(p) < NP) begin
        m_leaf[p] = lf;
        m_port[p] = dp;
      end
      if (done) m_run = 1'b1;
    end
  endtask

  // Holds reset low across one rising edge; released by the next drive.
  task automatic doReset(input logic [5:0] v);
    @(negedge clk);
    reset      = 1'b0;
    vld        = v;
    credit_vld = 1'b0;
    cfg_we     = 1'b0;
    cfg_done   = 1'b0;
    @(posedge clk);
    #1;
    modelReset();
  endtask

  task automatic test_reset();
    doReset('0);
    total_checks++;
    if (dout !== 49'd0) $display("[TB] FAIL reset_dout got %h want 0", dout);
    else pass_checks++;
    total_checks++;
    if (ack !== 6'd0) $display("[TB] FAIL reset_ack got %b want 0", ack);
    else pass_checks++;
    total_checks++;
    if (stat !== 32'd0) $display("[TB] FAIL reset_stat got %0d want 0", stat);
    else pass_checks++;
  endtask

  task automatic test_cfg();
    for (int c = 0; c < 2; c++) begin
      applyStimulus(6'h3F, makeData(1, c), 1'b0, 3'd0);
      #1;
      ea = exp_ack_q.pop_front();
      total_checks++;
      if (ack !== ea) $display("[TB] FAIL cfg_ack c=%0d got %b want %b", c, ack, ea);
      else pass_checks++;
      @(posedge clk); #1;
      ed = exp_dout_q.pop_front();
      total_checks++;
      if (dout !== ed) $display("[TB] FAIL cfg_dout c=%0d got %h want %h", c, dout, ed);
      else pass_checks++;
    end
    cfgWrite(3'd0, 5'd3,  4'd2,  1'b0);
    cfgWrite(3'd1, 5'd1,  4'd5,  1'b0);
    cfgWrite(3'd2, 5'd7,  4'd9,  1'b0);
    cfgWrite(3'd3, 5'd4,  4'd1,  1'b0);
    cfgWrite(3'd6, 5'd31, 4'd15, 1'b0);
    cfgWrite(3'd4, 5'd30, 4'd14, 1'b0);
    cfgWrite(3'd5, 5'd17, 4'd3,  1'b1);
  endtask

  task automatic test_single();
    logic [191:0] d;
    d = '0;
    d[31:0] = 32'hDEADBEEF;
    applyStimulus(6'h01, d, 1'b0, 3'd0);
    #1;
    ea = exp_ack_q.pop_front();
    total_checks++;
    if (ack !== ea) $display("[TB] FAIL single_ack got %b want %b", ack, ea);
    else pass_checks++;
    @(posedge clk); #1;
    ed = exp_dout_q.pop_front();
    total_checks++;
    if (dout !== ed) $display("[TB] FAIL single_dout got %h want %h", dout, ed);
    else pass_checks++;
    total_checks++;
    if (dout !== {5'd3, 4'd2, 1'b1, 7'd0, 32'hDEADBEEF})
      $display("[TB] FAIL single_const got %h want %h", dout, {5'd3, 4'd2, 1'b1, 7'd0, 32'hDEADBEEF});
    else pass_checks++;
    // route writes and cfg_done while running must have no effect
    cfgWrite(3'd0, 5'd31, 4'd15, 1'b1);
    d[31:0] = 32'h1234_5678;
    applyStimulus(6'h01, d, 1'b0, 3'd0);
    #1;
    ea = exp_ack_q.pop_front();
    total_checks++;
    if (ack !== ea) $display("[TB] FAIL runcfg_ack got %b want %b", ack, ea);
    else pass_checks++;
    @(posedge clk); #1;
    ed = exp_dout_q.pop_front();
    total_checks++;
    if (dout !== ed) $display("[TB] FAIL runcfg_dout got %h want %h", dout, ed);
    else pass_checks++;
  endtask

  task automatic test_round_robin();
    for (int c = 0; c < 12; c++) begin
      applyStimulus(6'h3F, makeData(2, c), 1'b0, 3'd0);
      #1;
      ea = exp_ack_q.pop_front();
      total_checks++;
      if (ack !== ea) $display("[TB] FAIL rr_ack c=%0d got %b want %b", c, ack, ea);
      else pass_checks++;
      @(posedge clk); #1;
      ed = exp_dout_q.pop_front();
      total_checks++;
      if (dout !== ed) $display("[TB] FAIL rr_dout c=%0d got %h want %h", c, dout, ed);
      else pass_checks++;
    end
  endtask

  task automatic test_credit();
    logic       cv;
    logic [2:0] cp;
    for (int c = 0; c < 136; c++) begin
      cv = (c == 131) || (c == 132);
      cp = (c == 131) ? 3'd7 : 3'd1;
      applyStimulus(6'h02, makeData(3, c), cv, cp);
      #1;
      ea = exp_ack_q.pop_front();
      total_checks++;
      if (ack !== ea) $display("[TB] FAIL credit_ack c=%0d got %b want %b", c, ack, ea);
      else pass_checks++;
      @(posedge clk); #1;
      ed = exp_dout_q.pop_front();
      total_checks++;
      if (dout !== ed) $display("[TB] FAIL credit_dout c=%0d got %h want %h", c, dout, ed);
      else pass_checks++;
    end
  endtask

  task automatic test_clamp();
    int c;
    c = 0;
    while (m_credit[2] > 100 && c < 200) begin
      applyStimulus(6'h04, makeData(4, c), 1'b0, 3'd0);
      #1;
      ea = exp_ack_q.pop_front();
      total_checks++;
      if (ack !== ea) $display("[TB] FAIL clamp_pre_ack c=%0d got %b want %b", c, ack, ea);
      else pass_checks++;
      @(posedge clk); #1;
      ed = exp_dout_q.pop_front();
      total_checks++;
      if (dout !== ed) $display("[TB] FAIL clamp_pre_dout c=%0d got %h want %h", c, dout, ed);
      else pass_checks++;
      c++;
    end
    for (int k = 0; k < 131; k++) begin
      applyStimulus(6'h04, makeData(5, k), (k == 0), 3'd2);
      #1;
      ea = exp_ack_q.pop_front();
      total_checks++;
      if (ack !== ea) $display("[TB] FAIL clamp_ack k=%0d got %b want %b", k, ack, ea);
      else pass_checks++;
      @(posedge clk); #1;
      ed = exp_dout_q.pop_front();
      total_checks++;
      if (dout !== ed) $display("[TB] FAIL clamp_dout k=%0d got %h want %h", k, dout, ed);
      else pass_checks++;
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(6'h3F, makeData(6, c), 1'b0, 3'd0);
      #1;
      ea = exp_ack_q.pop_front();
      total_checks++;
      if (ack !== ea) $display("[TB] FAIL mid_ack c=%0d got %b want %b", c, ack, ea);
      else pass_checks++;
      @(posedge clk); #1;
      ed = exp_dout_q.pop_front();
      total_checks++;
      if (dout !== ed) $display("[TB] FAIL mid_dout c=%0d got %h want %h", c, dout, ed);
      else pass_checks++;
    end
    doReset(6'h3F);
    total_checks++;
    if (dout !== 49'd0) $display("[TB] FAIL midrst_dout got %h want 0", dout);
    else pass_checks++;
    total_checks++;
    if (ack !== 6'd0) $display("[TB] FAIL midrst_ack got %b want 0", ack);
    else pass_checks++;
    for (int c = 0; c < 2; c++) begin
      applyStimulus(6'h3F, makeData(7, c), 1'b0, 3'd0);
      #1;
      ea = exp_ack_q.pop_front();
      total_checks++;
      if (ack !== ea) $display("[TB] FAIL postrst_ack c=%0d got %b want %b", c, ack, ea);
      else pass_checks++;
      @(posedge clk); #1;
      ed = exp_dout_q.pop_front();
      total_checks++;
      if (dout !== ed) $display("[TB] FAIL postrst_dout c=%0d got %h want %h", c, dout, ed);
      else pass_checks++;
    end
    cfgWrite(3'd0, 5'd9, 4'd7, 1'b1);
    for (int c = 0; c < 130; c++) begin
      applyStimulus(6'h01, makeData(8, c), 1'b0, 3'd0);
      #1;
      ea = exp_ack_q.pop_front();
      total_checks++;
      if (ack !== ea) $display("[TB] FAIL refill_ack c=%0d got %b want %b", c, ack, ea);
      else pass_checks++;
      @(posedge clk); #1;
      ed = exp_dout_q.pop_front();
      total_checks++;
      if (dout !== ed) $display("[TB] FAIL refill_dout c=%0d got %h want %h", c, dout, ed);
      else pass_checks++;
    end
  endtask

  task automatic test_stats();
    logic [31:0] exp_stat;
    doReset('0);
    cfgWrite(3'd3, 5'd4, 4'd1, 1'b1);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(6'h08, makeData(9, c), 1'b0, 3'd0);
      #1;
      ea = exp_ack_q.pop_front();
      total_checks++;
      if (ack !== ea) $display("[TB] FAIL stats_ack c=%0d got %b want %b", c, ack, ea);
      else pass_checks++;
      @(posedge clk); #1;
      ed = exp_dout_q.pop_front();
      total_checks++;
      if (dout !== ed) $display("[TB] FAIL stats_dout c=%0d got %h want %h", c, dout, ed);
      else pass_checks++;
    end
`ifdef LEAF_TX_STATS_EN
    exp_stat = 32'(m_cnt);
`else
    exp_stat = 32'd0;
`endif
    total_checks++;
    if (stat !== exp_stat) $display("[TB] FAIL stat_cnt got %0d want %0d", stat, exp_stat);
    else pass_checks++;
  endtask

  initial begin
    modelReset();
    $display("[TB] leaf_tx_packetizer bench start");
    test_reset();
    test_cfg();
    test_single();
    test_round_robin();
    test_credit();
    test_clamp();
    test_reset_mid();
    test_stats();
    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule
